// File: rtl/usb_ls_receiver_pkg.sv
// Shared types for the USB low-speed receive path: line states, PIDs and
// receiver FSM states.
package usb_ls_receiver_pkg;

    typedef enum logic [1:0] {
        SE0 = 2'b00,
        J   = 2'b01,
        K   = 2'b10,
        SE1 = 2'b11
    } d_port_t;

    typedef enum logic [3:0] {
        OUT   = 4'b0001,
        IN    = 4'b1001,
        SOF   = 4'b0101,
        SETUP = 4'b1101,
        DATA0 = 4'b0011,
        DATA1 = 4'b1011,
        ACK   = 4'b0010,
        NAK   = 4'b1010,
        STALL = 4'b1110
    } pid_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_SYNC,
        RX_DATA,
        RX_EOP
    } rx_state_t;

    // Six decoded ones in a row force a stuffed zero on the wire.
    localparam logic [2:0] STUFF_ONES = 3'd6;

    // SYNC history seeded so that seven shifted-in zeros are needed to clear it;
    // the K that leaves IDLE already counts as the first zero.
    localparam logic [6:0] SYNC_SEED = 7'b1111110;

    // A PID travels with its ones-complement check nibble in the upper half.
    function automatic logic [7:0] pid_byte(input pid_t p);
        return {~p, p};
    endfunction

endpackage

// File: rtl/usb_cdr.sv
// Clock/data recovery: synchronizes the raw D+/D- pair, re-phases a bit
// counter on every line transition and samples the line mid-bit.
module usb_cdr
    import usb_ls_receiver_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic    clk,
    input  logic    reset,
    input  d_port_t d,
    output d_port_t line_state,
    output logic    strobe,
    output d_port_t q
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    d_port_t       sync_q [SYNC_STAGES];
    d_port_t       sync_d [SYNC_STAGES];
    logic [CW-1:0] phase_q, phase_d;
    d_port_t       q_q, q_d;

    always_comb begin
        sync_d[0] = d;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign line_state = sync_q[SYNC_STAGES-1];
    assign strobe     = (phase_q == MID);
    assign q          = q_q;

    // The reload is taken from the last stage's input so the counter reads 0
    // in the same cycle the new line state first appears.
    always_comb begin
        if (sync_d[SYNC_STAGES-1] != sync_q[SYNC_STAGES-1]) begin
            phase_d = '0;
        end else if (phase_q == LAST) begin
            phase_d = '0;
        end else begin
            phase_d = phase_q + CW'(1);
        end
        q_d = strobe ? line_state : q_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= J;
            end
            phase_q <= '0;
            q_q     <= J;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            phase_q <= phase_d;
            q_q     <= q_d;
        end
    end

endmodule

// File: rtl/usb_ls_receiver.sv
// USB low-speed receive front end: CDR followed by NRZI decode, bit
// unstuffing, SYNC/EOP detection and LSB-first byte assembly.
module usb_ls_receiver
    import usb_ls_receiver_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  d_port_t    d,
    output d_port_t    line_state,
    output logic [7:0] data,
    output logic       active,
    output logic       valid,
    output logic       error
);

    logic    strobe;
    d_port_t q;

    usb_cdr #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_cdr (
        .clk       (clk),
        .reset     (reset),
        .d         (d),
        .line_state(line_state),
        .strobe    (strobe),
        .q         (q)
    );

    rx_state_t  state_q, state_d;
    logic [6:0] sync_sr_q, sync_sr_d;
    logic [2:0] ones_q, ones_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic       se0_seen_q, se0_seen_d;
    logic [7:0] data_q, data_d;
    logic       active_q, active_d;
    logic       valid_q, valid_d;
    logic       error_q, error_d;
    logic       nrzi_bit;

    // On a strobe cycle line_state is the sample q is about to take, while q
    // still holds the previous bit's sample.
    assign nrzi_bit = (line_state == q);

    always_comb begin
        state_d    = state_q;
        sync_sr_d  = sync_sr_q;
        ones_d     = ones_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        se0_seen_d = se0_seen_q;
        data_d     = data_q;
        active_d   = active_q;
        valid_d    = 1'b0;
        error_d    = 1'b0;

        if (strobe) begin
            case (state_q)
                RX_IDLE: begin
                    if (line_state == K) begin
                        state_d   = RX_SYNC;
                        sync_sr_d = SYNC_SEED;
                    end
                end

                RX_SYNC: begin
                    if (line_state == SE0) begin
                        state_d = RX_IDLE;
                    end else if (line_state == SE1) begin
                        state_d    = RX_EOP;
                        se0_seen_d = 1'b0;
                        error_d    = 1'b1;
                    end else if (nrzi_bit && sync_sr_q == 7'd0) begin
                        state_d   = RX_DATA;
                        active_d  = 1'b1;
                        ones_d    = 3'd1;
                        bit_cnt_d = 3'd0;
                    end else begin
                        sync_sr_d = {sync_sr_q[5:0], nrzi_bit};
                    end
                end

                RX_DATA: begin
                    if (line_state == SE0) begin
                        state_d    = RX_EOP;
                        se0_seen_d = 1'b1;
                        error_d    = (bit_cnt_q != 3'd0);
                    end else if (line_state == SE1) begin
                        state_d    = RX_EOP;
                        se0_seen_d = 1'b0;
                        error_d    = 1'b1;
                    end else if (ones_q == STUFF_ONES) begin
                        // The bit after six ones must be a stuffed zero.
                        if (nrzi_bit) begin
                            state_d    = RX_EOP;
                            se0_seen_d = 1'b0;
                            error_d    = 1'b1;
                        end else begin
                            ones_d = 3'd0;
                        end
                    end else begin
                        ones_d    = nrzi_bit ? ones_q + 3'd1 : 3'd0;
                        shift_d   = {nrzi_bit, shift_q[6:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            data_d  = {nrzi_bit, shift_q};
                            valid_d = 1'b1;
                        end
                    end
                end

                RX_EOP: begin
                    if (line_state == SE0) begin
                        se0_seen_d = 1'b1;
                    end else if (line_state == J && se0_seen_q) begin
                        state_d  = RX_IDLE;
                        active_d = 1'b0;
                    end
                end

                default: begin
                    state_d = RX_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RX_IDLE;
            sync_sr_q  <= '0;
            ones_q     <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            se0_seen_q <= 1'b0;
            data_q     <= '0;
            active_q   <= 1'b0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_sr_q  <= sync_sr_d;
            ones_q     <= ones_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            se0_seen_q <= se0_seen_d;
            data_q     <= data_d;
            active_q   <= active_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
        end
    end

    assign data   = data_q;
    assign active = active_q;
    assign valid  = valid_q;
    assign error  = error_q;

endmodule

// File: tb/tb_usb_ls_receiver.sv
// Bench for usb_ls_receiver: an encoder model builds NRZI/stuffed line traffic
// from byte lists and the received bytes and pulses are compared against it.
module tb_usb_ls_receiver;
    import usb_ls_receiver_pkg::*;

    localparam int CLKS_PER_BIT = 16;
    localparam int SYNC_STAGES  = 2;
    localparam int PERIOD       = 10;
    localparam int BIT_T        = CLKS_PER_BIT * PERIOD;
    localparam int NVEC         = 8;
    localparam int K_RAND       = 0;
    localparam int K_FIXED      = 1;
    localparam int K_ERR        = 2;

    logic       clk = 1'b0;
    logic       reset;
    d_port_t    d;
    d_port_t    line_state;
    logic [7:0] data;
    logic       active;
    logic       valid;
    logic       error;

    usb_ls_receiver #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .d         (d),
        .line_state(line_state),
        .data      (data),
        .active    (active),
        .valid     (valid),
        .error     (error)
    );

    always #(PERIOD / 2) clk = ~clk;

    typedef struct {
        bit   send_pid;
        pid_t pid;
        int   n_payload;
        int   kind;
        int   gap;
        int   exp_valid;
        int   exp_errors;
    } vec_t;

    int         vec_cnt = 0;
    int         miscompares = 0;
    logic [7:0] rx_bytes[$];
    int         err_pulses = 0;
    int         active_rises = 0;
    logic       active_prev = 1'b0;
    d_port_t    tx_q[$];
    vec_t       vecs[NVEC];
    pid_t       pid_pool[9];

    // Collect what the receiver delivers, sampled on the inactive edge.
    always @(negedge clk) begin
        if (valid) rx_bytes.push_back(data);
        if (error) err_pulses++;
        if (active && !active_prev) active_rises++;
        active_prev = active;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vec_cnt++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference encoder: SYNC, LSB-first bytes with a zero after every six
    // ones (SYNC's final one counts), NRZI from idle J, then SE0 SE0 J.
    task automatic buildPacket(input logic [7:0] bytes[$], input bit inject_ones);
        bit      bits[$];
        int      ones;
        bit      b;
        d_port_t level;
        tx_q.delete();
        for (int i = 0; i < 7; i++) bits.push_back(1'b0);
        bits.push_back(1'b1);
        ones = 1;
        foreach (bytes[k]) begin
            for (int i = 0; i < 8; i++) begin
                b = bytes[k][i];
                bits.push_back(b);
                ones = b ? ones + 1 : 0;
                if (ones == 6) begin
                    bits.push_back(1'b0);
                    ones = 0;
                end
            end
        end
        if (inject_ones) begin
            for (int i = 0; i < 7; i++) bits.push_back(1'b1);
        end
        level = J;
        foreach (bits[i]) begin
            if (!bits[i]) level = (level == J) ? K : J;
            tx_q.push_back(level);
        end
        tx_q.push_back(SE0);
        tx_q.push_back(SE0);
        tx_q.push_back(J);
    endtask

    task automatic applyStimulus(input int reset_at, output logic active_at_eop);
        time t0;
        active_at_eop = 1'b0;
        for (int i = 0; i < tx_q.size(); i++) begin
            if (i == tx_q.size() - 3) active_at_eop = active;
            d = tx_q[i];
            if (i == reset_at) begin
                t0 = $time;
                #(BIT_T / 2);
                reset = 1'b1;
                @(negedge clk);
                @(negedge clk);
                checkOutput("midreset_line_state", line_state, J);
                checkOutput("midreset_data", data, 8'h00);
                checkOutput("midreset_active", active, 1'b0);
                checkOutput("midreset_valid", valid, 1'b0);
                checkOutput("midreset_error", error, 1'b0);
                reset = 1'b0;
                rx_bytes.delete();
                err_pulses   = 0;
                active_rises = 0;
                #(t0 + BIT_T - $time);
            end else begin
                #(BIT_T);
            end
        end
    endtask

    task automatic runPacket(input string name, input logic [7:0] tx_bytes[$], input bit inject,
                             input int gap, input int reset_at, input int exp_valid,
                             input logic [7:0] exp_bytes[$], input int exp_errors, input bit exp_active);
        logic act_eop;
        int   n;
        buildPacket(tx_bytes, inject);
        rx_bytes.delete();
        err_pulses   = 0;
        active_rises = 0;
        repeat (gap) @(negedge clk);
        #($urandom_range(1, 4));
        applyStimulus(reset_at, act_eop);
        checkOutput({name, "_valid_count"}, rx_bytes.size(), exp_valid);
        n = (rx_bytes.size() < exp_bytes.size()) ? rx_bytes.size() : exp_bytes.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_byte%0d", name, i), rx_bytes[i], exp_bytes[i]);
        end
        checkOutput({name, "_error_count"}, err_pulses, exp_errors);
        checkOutput({name, "_active_rises"}, active_rises, exp_active);
        checkOutput({name, "_active_before_eop"}, act_eop, exp_active);
        checkOutput({name, "_active_after_eop"}, active, 1'b0);
        checkOutput({name, "_line_state_end"}, line_state, J);
    endtask

    initial begin
        #(60000 * PERIOD);
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] txb[$];
        logic [7:0] none[$];
        int         strobes;
        int         bad_gaps;
        int         last;
        int         gap;

        pid_pool = '{OUT, IN, SOF, SETUP, DATA0, DATA1, ACK, NAK, STALL};
        vecs[0] = '{1'b1, DATA0, 10, K_RAND,  -1, 11, 0};
        vecs[1] = '{1'b1, DATA1, 10, K_RAND,   8, 11, 0};
        vecs[2] = '{1'b1, DATA0,  2, K_FIXED, -1,  3, 0};
        vecs[3] = '{1'b0, DATA0,  0, K_ERR,   -1,  0, 1};
        for (int v = 4; v < NVEC; v++) begin
            vecs[v] = '{1'b1, pid_pool[$urandom_range(0, 8)], int'($urandom_range(0, 8)), K_RAND, -1, 0, 0};
            vecs[v].exp_valid = 1 + vecs[v].n_payload;
        end

        reset = 1'b1;
        d     = J;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_line_state", line_state, J);
        checkOutput("reset_data", data, 8'h00);
        checkOutput("reset_active", active, 1'b0);
        checkOutput("reset_valid", valid, 1'b0);
        checkOutput("reset_error", error, 1'b0);
        reset = 1'b0;

        // 100 bit times of idle J: one strobe every CLKS_PER_BIT clocks, no activity.
        strobes  = 0;
        bad_gaps = 0;
        last     = -1;
        for (int c = 0; c < 100 * CLKS_PER_BIT; c++) begin
            @(negedge clk);
            if (dut.u_cdr.strobe) begin
                if (last >= 0 && c - last != CLKS_PER_BIT) bad_gaps++;
                last = c;
                strobes++;
            end
        end
        checkOutput("idle_strobe_count", strobes, 100);
        checkOutput("idle_strobe_spacing_errors", bad_gaps, 0);
        checkOutput("idle_valid_count", rx_bytes.size(), 0);
        checkOutput("idle_error_count", err_pulses, 0);
        checkOutput("idle_active_rises", active_rises, 0);

        for (int v = 0; v < NVEC; v++) begin
            txb.delete();
            if (vecs[v].send_pid) txb.push_back(pid_byte(vecs[v].pid));
            if (vecs[v].kind == K_RAND) begin
                for (int i = 0; i < vecs[v].n_payload; i++) txb.push_back(8'($urandom_range(0, 255)));
            end else if (vecs[v].kind == K_FIXED) begin
                txb.push_back(8'hFF);
                txb.push_back(8'h7E);
            end
            gap = (vecs[v].gap < 0) ? int'($urandom_range(20, 60)) : vecs[v].gap;
            runPacket($sformatf("vec%0d", v), txb, vecs[v].kind == K_ERR, gap, -1,
                      vecs[v].exp_valid, (vecs[v].kind == K_ERR) ? none : txb,
                      vecs[v].exp_errors, 1'b1);
        end

        // Reset in the middle of the first payload byte aborts silently.
        txb.delete();
        txb.push_back(pid_byte(DATA0));
        for (int i = 0; i < 3; i++) txb.push_back(8'h55);
        runPacket("reset_abort", txb, 1'b0, 30, 8 + 8 + 4, 0, none, 0, 1'b0);

        txb.delete();
        txb.push_back(pid_byte(DATA0));
        for (int i = 0; i < 3; i++) txb.push_back(8'($urandom_range(0, 255)));
        runPacket("after_reset", txb, 1'b0, 30, -1, 4, txb, 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
